// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and sizes for the key-matrix arbiter
package matrix_pkg;

    localparam int ROWS_DEF = 16;
    localparam int ROW_W    = 4;
    localparam int COL_W    = 3;
    localparam int DATA_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UPD_RD,
        ST_UPD_MOD,
        ST_UPD_WR,
        ST_CLR
    } state_t;

endpackage

// File: rtl/matrix_arb.sv
// rtl/matrix_arb.sv - arbitrates key-matrix RAM between scan reads, key-event RMW and full clear
module matrix_arb
    import matrix_pkg::*;
#(
    parameter int ROWS = ROWS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_ena,
    input  logic [ROW_W-1:0]  scan_row,
    output logic [DATA_W-1:0] scan_data,
    input  logic              upd_valid,
    input  logic [ROW_W-1:0]  upd_row,
    input  logic [COL_W-1:0]  upd_col,
    input  logic              upd_set,
    output logic              upd_ready,
    input  logic              clr_req,
    output logic [ROW_W-1:0]  ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_scan_data;
    logic                r_scan_vld;
    logic [ROW_W-1:0]    r_row;
    logic [COL_W-1:0]    r_col;
    logic                r_set;
    logic [DATA_W-1:0]   r_word;
    logic [ROW_W-1:0]    r_cnt;
    logic                r_clr_pend;

    logic                w_clr_pend;
    logic [DATA_W-1:0]   w_mod_word;

    // A clear request in the current cycle already blocks new updates.
    assign w_clr_pend = r_clr_pend | clr_req;

    always_comb begin
        w_mod_word          = r_word;
        w_mod_word[r_col]   = r_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_scan_data <= '0;
            r_scan_vld  <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_set       <= 1'b0;
            r_word      <= '0;
            r_cnt       <= '0;
            r_clr_pend  <= 1'b1;
        end else if (clk_ena) begin
            r_clr_pend <= w_clr_pend;
            case (r_state)
                ST_IDLE: begin
                    if (r_scan_vld) begin
                        r_scan_data <= ram_dout;
                    end
                    if (w_clr_pend) begin
                        r_state    <= ST_CLR;
                        r_cnt      <= '0;
                        r_scan_vld <= 1'b0;
                    end else if (upd_valid) begin
                        r_state    <= ST_UPD_RD;
                        r_row      <= upd_row;
                        r_col      <= upd_col;
                        r_set      <= upd_set;
                        r_scan_vld <= 1'b0;
                    end else begin
                        r_scan_vld <= 1'b1;
                    end
                end
                ST_UPD_RD: begin
                    r_state <= ST_UPD_MOD;
                end
                ST_UPD_MOD: begin
                    r_word  <= ram_dout;
                    r_state <= ST_UPD_WR;
                end
                ST_UPD_WR: begin
                    r_state <= ST_IDLE;
                end
                ST_CLR: begin
                    // Requests seen during the pass are satisfied by it.
                    if (r_cnt == ROW_W'(ROWS - 1)) begin
                        r_state    <= ST_IDLE;
                        r_clr_pend <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_clr_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ram_addr = scan_row;
        ram_din  = '0;
        case (r_state)
            ST_UPD_RD, ST_UPD_MOD: ram_addr = r_row;
            ST_UPD_WR: begin
                ram_addr = r_row;
                ram_din  = w_mod_word;
            end
            ST_CLR:    ram_addr = r_cnt;
            default:   ram_addr = scan_row;
        endcase
    end

    assign ram_we    = clk_ena && ((r_state == ST_UPD_WR) || (r_state == ST_CLR));
    assign upd_ready = (r_state == ST_IDLE) && !w_clr_pend && clk_ena;
    assign busy      = (r_state != ST_IDLE) || r_clr_pend;
    assign scan_data = r_scan_data;

endmodule

// File: tb/tb_matrix_arb.sv
// tb/tb_matrix_arb.sv - directed self-checking bench for matrix_arb with a behavioural RAM
module tb_matrix_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clk_ena;
    logic [3:0] scan_row;
    logic [7:0] scan_data;
    logic       upd_valid;
    logic [3:0] upd_row;
    logic [2:0] upd_col;
    logic       upd_set;
    logic       upd_ready;
    logic       clr_req;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [16];
    int         wr_cnt = 0;
    logic       bad_we = 1'b0;

    matrix_arb #(.ROWS(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_ena   (clk_ena),
        .scan_row  (scan_row),
        .scan_data (scan_data),
        .upd_valid (upd_valid),
        .upd_row   (upd_row),
        .upd_col   (upd_col),
        .upd_set   (upd_set),
        .upd_ready (upd_ready),
        .clr_req   (clr_req),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clk_ena) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_we && !clk_ena) bad_we = 1'b1;
        if (ram_we && clk_ena) wr_cnt = wr_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    function automatic logic all_zero();
        logic z;
        z = 1'b1;
        for (int i = 0; i < 16; i++) if (mem[i] !== 8'h00) z = 1'b0;
        return z;
    endfunction

    task automatic do_event(input string tag, input logic [3:0] row, input logic [2:0] col, input logic set);
        int n;
        n = 0;
        while (!upd_ready && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_ready"}, 32'(upd_ready), 32'd1);
        upd_row   = row;
        upd_col   = col;
        upd_set   = set;
        upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        step();
        step();
        step();
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA5;
        ram_dout  = 8'h00;
        reset_n   = 1'b0;
        clk_ena   = 1'b1;
        scan_row  = 4'd0;
        upd_valid = 1'b0;
        upd_row   = 4'd0;
        upd_col   = 3'd0;
        upd_set   = 1'b0;
        clr_req   = 1'b0;
        step();
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_scan_data", 32'(scan_data), 32'h00);
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);

        // Power-up clear
        reset_n = 1'b1;
        wr_cnt  = 0;
        wait_idle("init_clear_timeout");
        chk("init_clear_writes", 32'(wr_cnt), 32'd16);
        chk("init_clear_zero", 32'(all_zero()), 32'd1);
        chk("init_upd_ready", 32'(upd_ready), 32'd1);

        // Row 6 col 0 press, then scan it
        upd_row = 4'd6; upd_col = 3'd0; upd_set = 1'b1; upd_valid = 1'b1;
        #1;
        chk("r6_ready", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        chk("r6_rd_busy", 32'(busy), 32'd1);
        chk("r6_rd_addr", 32'(ram_addr), 32'd6);
        step();
        chk("r6_mod_we", 32'(ram_we), 32'd0);
        step();
        chk("r6_wr_we", 32'(ram_we), 32'd1);
        chk("r6_wr_din", 32'(ram_din), 32'h01);
        step();
        chk("r6_mem", 32'(mem[6]), 32'h01);
        chk("r6_idle", 32'(busy), 32'd0);
        scan_row = 4'd6;
        step();
        step();
        chk("r6_scan", 32'(scan_data), 32'h01);

        // Row 3: press col 2, col 5, release col 2
        do_event("r3a", 4'd3, 3'd2, 1'b1);
        chk("r3_after_c2", 32'(mem[3]), 32'h04);
        do_event("r3b", 4'd3, 3'd5, 1'b1);
        chk("r3_after_c5", 32'(mem[3]), 32'h24);
        do_event("r3c", 4'd3, 3'd2, 1'b0);
        chk("r3_after_rel", 32'(mem[3]), 32'h20);
        scan_row = 4'd3;
        step();
        step();
        chk("r3_scan", 32'(scan_data), 32'h20);

        // Idempotent set still writes once
        w0 = wr_cnt;
        do_event("r3d", 4'd3, 3'd5, 1'b1);
        chk("idem_writes", 32'(wr_cnt - w0), 32'd1);
        chk("idem_value", 32'(mem[3]), 32'h20);

        // Clear request during UPD_MOD; second request during CLR is absorbed
        upd_row = 4'd10; upd_col = 3'd7; upd_set = 1'b1; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("cm_wr_we", 32'(ram_we), 32'd1);
        chk("cm_wr_din", 32'(ram_din), 32'h80);
        step();
        chk("cm_mem10", 32'(mem[10]), 32'h80);
        chk("cm_pending_busy", 32'(busy), 32'd1);
        w0 = wr_cnt;
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wait_idle("cm_clear_timeout");
        chk("cm_clear_writes", 32'(wr_cnt - w0), 32'd16);
        chk("cm_clear_zero", 32'(all_zero()), 32'd1);
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) step();
        chk("cm_no_second_pass", 32'(wr_cnt - w0), 32'd0);

        // Clear and update together: clear wins
        upd_row = 4'd1; upd_col = 3'd1; upd_set = 1'b1; upd_valid = 1'b1; clr_req = 1'b1;
        #1;
        chk("conf_ready", 32'(upd_ready), 32'd0);
        step();
        upd_valid = 1'b0;
        clr_req   = 1'b0;
        chk("conf_busy", 32'(busy), 32'd1);
        wait_idle("conf_timeout");
        chk("conf_row1", 32'(mem[1]), 32'h00);

        // Throttled enable: one enabled cycle in three
        w0 = wr_cnt;
        upd_row = 4'd12; upd_col = 3'd3; upd_set = 1'b1;
        for (int i = 0; i < 12; i++) begin
            clk_ena   = (i % 3 == 0);
            upd_valid = (i == 0);
            step();
        end
        upd_valid = 1'b0;
        clk_ena   = 1'b1;
        chk("ena_mem12", 32'(mem[12]), 32'h08);
        chk("ena_writes", 32'(wr_cnt - w0), 32'd1);
        chk("ena_no_bad_we", 32'(bad_we), 32'd0);
        scan_row = 4'd12;
        step();
        step();
        chk("ena_scan", 32'(scan_data), 32'h08);

        // Reset during UPD_RD abandons the write
        w0 = wr_cnt;
        upd_row = 4'd9; upd_col = 3'd4; upd_set = 1'b1; upd_valid = 1'b1;
        step();
        upd_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("mr_we", 32'(ram_we), 32'd0);
        step();
        chk("mr_scan_data", 32'(scan_data), 32'h00);
        chk("mr_mem9", 32'(mem[9]), 32'h00);
        chk("mr_no_write", 32'(wr_cnt - w0), 32'd0);
        reset_n = 1'b1;
        w0 = wr_cnt;
        chk("mr_busy", 32'(busy), 32'd1);
        wait_idle("mr_clear_timeout");
        chk("mr_clear_writes", 32'(wr_cnt - w0), 32'd16);
        chk("mr_mem9_after", 32'(mem[9]), 32'h00);
        chk("mr_upd_ready", 32'(upd_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
